// File: rtl/iir_mac_seq_if.sv
// Sample, output and coefficient-config handshake bundle for the iir_mac_seq sequencer.
// The master side drives samples and config writes; the slave side is the filter.
interface iir_mac_seq_if #(
    parameter int DATA_W = 15,
    parameter int COEF_W = 16
);
    logic [DATA_W-1:0] x_in;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] y_out;
    logic              out_valid;
    logic              out_ready;
    logic              cfg_we;
    logic [2:0]        cfg_addr;
    logic [COEF_W-1:0] cfg_wdata;
    logic              cfg_drop;
    logic              sat_flag;

    modport master (
        output x_in, in_valid, out_ready, cfg_we, cfg_addr, cfg_wdata,
        input  in_ready, y_out, out_valid, cfg_drop, sat_flag
    );

    modport slave (
        input  x_in, in_valid, out_ready, cfg_we, cfg_addr, cfg_wdata,
        output in_ready, y_out, out_valid, cfg_drop, sat_flag
    );
endinterface

// File: rtl/iir_mac_seq.sv
// Direct-form-I biquad that time-shares one multiplier over its five taps:
// one sample in, five MAC cycles, one rounding/saturation cycle, one output.
module iir_mac_seq #(
    parameter int DATA_W = 15,
    parameter int COEF_W = 16,
    parameter int FRAC   = 13,
    parameter int ACC_W  = 34
) (
    input  logic          clk,
    input  logic          rst,
    iir_mac_seq_if.slave  bus
);
    localparam int PROD_W = DATA_W + COEF_W;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_MAC   = 2'd1;
    localparam logic [1:0] S_ROUND = 2'd2;
    localparam logic [1:0] S_OUT   = 2'd3;

    localparam logic signed [COEF_W-1:0] COEF_ONE = COEF_W'(2**FRAC);
    localparam logic signed [DATA_W-1:0] Y_MAX    = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] Y_MIN    = ~Y_MAX;
    localparam logic signed [ACC_W-1:0]  SAT_HI   = ACC_W'(Y_MAX);
    localparam logic signed [ACC_W-1:0]  SAT_LO   = ACC_W'(Y_MIN);
    localparam logic signed [ACC_W-1:0]  RND_HALF = ACC_W'(2**(FRAC-1));

    logic [1:0]               r_state;
    logic [2:0]               r_tap;
    logic signed [DATA_W-1:0] r_x0, r_x1, r_x2, r_y1, r_y2;
    logic signed [DATA_W-1:0] r_y_out;
    logic signed [ACC_W-1:0]  r_acc;
    logic                     r_cfg_drop;
    logic                     r_sat;

    logic                     w_idle, w_accept, w_cfg_take, w_clear;
    logic signed [COEF_W-1:0] w_coef;
    logic signed [DATA_W-1:0] w_opnd;
    logic signed [PROD_W-1:0] w_prod;
    logic signed [ACC_W-1:0]  w_prod_ext;
    logic signed [ACC_W-1:0]  w_rnd, w_shr;
    logic                     w_hi, w_lo;
    logic signed [DATA_W-1:0] w_y;

    assign w_idle     = (r_state == S_IDLE);
    assign w_accept   = w_idle && bus.in_valid;
    assign w_cfg_take = w_idle && bus.cfg_we;
    assign w_clear    = w_cfg_take && (bus.cfg_addr == 3'd5);

    // Coefficient bank: b0, b1, b2, a1, a2 at config addresses 0..4.
    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_coef
            logic signed [COEF_W-1:0] r_c;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst)
                    r_c <= (gi == 0) ? COEF_ONE : '0;
                else if (w_cfg_take && bus.cfg_addr == 3'(gi))
                    r_c <= bus.cfg_wdata;
            end
        end
    endgenerate

    always_comb begin
        w_coef = g_coef[0].r_c;
        w_opnd = r_x0;
        case (r_tap)
            3'd1: begin w_coef = g_coef[1].r_c; w_opnd = r_x1; end
            3'd2: begin w_coef = g_coef[2].r_c; w_opnd = r_x2; end
            3'd3: begin w_coef = g_coef[3].r_c; w_opnd = r_y1; end
            3'd4: begin w_coef = g_coef[4].r_c; w_opnd = r_y2; end
            default: ;
        endcase
    end

    assign w_prod     = w_coef * w_opnd;
    assign w_prod_ext = {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};

    // Round half up via +0.5 LSB and arithmetic shift, then clamp to the output range.
    assign w_rnd = r_acc + RND_HALF;
    assign w_shr = w_rnd >>> FRAC;
    assign w_hi  = (w_shr > SAT_HI);
    assign w_lo  = (w_shr < SAT_LO);
    assign w_y   = w_hi ? Y_MAX : (w_lo ? Y_MIN : w_shr[DATA_W-1:0]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_tap      <= '0;
            r_x0       <= '0;
            r_x1       <= '0;
            r_x2       <= '0;
            r_y1       <= '0;
            r_y2       <= '0;
            r_y_out    <= '0;
            r_acc      <= '0;
            r_cfg_drop <= 1'b0;
            r_sat      <= 1'b0;
        end else begin
            r_cfg_drop <= bus.cfg_we && !w_idle;
            case (r_state)
                S_IDLE: begin
                    if (w_clear) begin
                        r_x1  <= '0;
                        r_x2  <= '0;
                        r_y1  <= '0;
                        r_y2  <= '0;
                        r_sat <= 1'b0;
                    end
                    if (w_accept) begin
                        r_x0    <= bus.x_in;
                        r_acc   <= '0;
                        r_tap   <= '0;
                        r_state <= S_MAC;
                    end
                end
                S_MAC: begin
                    // Feedback taps (a1, a2) are subtracted.
                    if (r_tap >= 3'd3)
                        r_acc <= r_acc - w_prod_ext;
                    else
                        r_acc <= r_acc + w_prod_ext;
                    if (r_tap == 3'd4)
                        r_state <= S_ROUND;
                    else
                        r_tap <= r_tap + 3'd1;
                end
                S_ROUND: begin
                    r_y_out <= w_y;
                    r_x2    <= r_x1;
                    r_x1    <= r_x0;
                    r_y2    <= r_y1;
                    r_y1    <= w_y;
                    if (w_hi || w_lo)
                        r_sat <= 1'b1;
                    r_state <= S_OUT;
                end
                default: begin
                    if (bus.out_ready)
                        r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = w_idle;
    assign bus.out_valid = (r_state == S_OUT);
    assign bus.y_out     = r_y_out;
    assign bus.cfg_drop  = r_cfg_drop;
    assign bus.sat_flag  = r_sat;
endmodule

// File: tb/tb_iir_mac_seq.sv
// Directed bench for iir_mac_seq: a vector table of config writes and samples with
// hand-computed outputs, plus sequences for backpressure, dropped writes and mid-op reset.
module tb_iir_mac_seq;
    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    iir_mac_seq_if #(.DATA_W(15), .COEF_W(16)) bus ();

    iir_mac_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        bit    do_cfg;
        int    addr;
        int    wdata;
        bit    do_send;
        int    x;
        int    y_exp;
        bit    sat_exp;
        string name;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit do_cfg, input int addr, input int wdata, input bit do_send,
                       input int x, input int y_exp, input bit sat_exp, input string name);
        vec_t v;
        v.do_cfg = do_cfg; v.addr = addr; v.wdata = wdata; v.do_send = do_send;
        v.x = x; v.y_exp = y_exp; v.sat_exp = sat_exp; v.name = name;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cfg_write(input int addr, input int wdata);
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = 3'(addr);
        bus.cfg_wdata = 16'(wdata);
        @(negedge clk);
        bus.cfg_we    = 1'b0;
    endtask

    // Present a sample (optionally with a same-cycle config write) and return after the accept edge.
    task automatic start_sample(input int x, input bit do_cfg, input int addr, input int wdata);
        int n;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_wait", int'(bus.in_ready), 1);
        bus.in_valid = 1'b1;
        bus.x_in     = 15'(x);
        if (do_cfg) begin
            bus.cfg_we    = 1'b1;
            bus.cfg_addr  = 3'(addr);
            bus.cfg_wdata = 16'(wdata);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.cfg_we   = 1'b0;
    endtask

    // Count sample points from the first one after accept until out_valid (bounded).
    task automatic wait_out(output int lat, output int ir_hi, output int y);
        int k;
        k = 1;
        ir_hi = 0;
        while (!bus.out_valid && k < 30) begin
            if (bus.in_ready) ir_hi++;
            @(negedge clk);
            k++;
        end
        if (bus.in_ready) ir_hi++;
        lat = bus.out_valid ? k : -1;
        y   = int'($signed(bus.y_out));
    endtask

    task automatic send(input string name, input int x, input int y_exp, input bit sat_exp,
                        input bit do_cfg, input int addr, input int wdata);
        int lat, ir_hi, y;
        start_sample(x, do_cfg, addr, wdata);
        wait_out(lat, ir_hi, y);
        check({name, "_latency"}, lat, 7);
        check({name, "_in_ready_low"}, ir_hi, 0);
        check({name, "_y"}, y, y_exp);
        $display("sample %s: x=%0d y=%0d latency=%0d", name, x, y, lat);
        @(negedge clk);
        check({name, "_out_valid_drop"}, int'(bus.out_valid), 0);
        check({name, "_sat"}, int'(bus.sat_flag), int'(sat_exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat, ir_hi, y;

        rst           = 1'b0;
        bus.x_in      = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.cfg_we    = 1'b0;
        bus.cfg_addr  = '0;
        bus.cfg_wdata = '0;

        // Reset defaults (passthrough), rounding with b0=0.5, recursion, saturation.
        add(0, 0, 0,      1, 1000,   1000,   0, "t1_1000");
        add(0, 0, 0,      1, 4,      4,      0, "t1_4");
        add(0, 0, 0,      1, -5,     -5,     0, "t1_m5");
        add(1, 0, 4096,   0, 0,      0,      0, "t2_b0_half");
        add(0, 0, 0,      1, 1000,   500,    0, "t2_1000");
        add(0, 0, 0,      1, 3,      2,      0, "t2_3");
        add(0, 0, 0,      1, -3,     -1,     0, "t2_m3");
        add(1, 0, 8192,   0, 0,      0,      0, "t3_b0_one");
        add(1, 3, -4096,  0, 0,      0,      0, "t3_a1");
        add(1, 5, 0,      0, 0,      0,      0, "t3_clear");
        add(0, 0, 0,      1, 1000,   1000,   0, "t3_imp");
        add(0, 0, 0,      1, 0,      500,    0, "t3_r1");
        add(0, 0, 0,      1, 0,      250,    0, "t3_r2");
        add(0, 0, 0,      1, 0,      125,    0, "t3_r3");
        add(0, 0, 0,      1, 0,      63,     0, "t3_r4");
        add(0, 0, 0,      1, 0,      32,     0, "t3_r5");
        add(1, 5, 0,      1, 0,      0,      0, "t3_clear_send");
        add(1, 3, 0,      0, 0,      0,      0, "t4_a1_zero");
        add(1, 0, 24576,  1, 10000,  16383,  1, "t4_pos_sat");
        add(0, 0, 0,      1, -10000, -16384, 1, "t4_neg_sat");
        add(1, 5, 0,      0, 0,      0,      0, "t4_clear_sat");
        add(1, 0, 8192,   0, 0,      0,      0, "t5_b0_one");

        #23;
        check("rst_in_ready",  int'(bus.in_ready),  1);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_y_out",     int'(bus.y_out),     0);
        check("rst_cfg_drop",  int'(bus.cfg_drop),  0);
        check("rst_sat_flag",  int'(bus.sat_flag),  0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            if (vecs[i].do_send) begin
                send(vecs[i].name, vecs[i].x, vecs[i].y_exp, vecs[i].sat_exp,
                     vecs[i].do_cfg, vecs[i].addr, vecs[i].wdata);
            end else begin
                cfg_write(vecs[i].addr, vecs[i].wdata);
                $display("cfg %s: addr=%0d data=%0d drop=%0b sat=%0b", vecs[i].name,
                         vecs[i].addr, vecs[i].wdata, bus.cfg_drop, bus.sat_flag);
                check({vecs[i].name, "_cfg_drop"}, int'(bus.cfg_drop), 0);
                check({vecs[i].name, "_sat"}, int'(bus.sat_flag), int'(vecs[i].sat_exp));
            end
        end

        // Backpressure: output held while out_ready=0, a presented sample is ignored.
        bus.out_ready = 1'b0;
        start_sample(100, 1'b0, 0, 0);
        wait_out(lat, ir_hi, y);
        check("t5_bp_latency", lat, 7);
        bus.in_valid = 1'b1;
        bus.x_in     = 15'(555);
        for (int i = 0; i < 10; i++) begin
            check("t5_bp_out_valid", int'(bus.out_valid), 1);
            check("t5_bp_y", int'($signed(bus.y_out)), 100);
            check("t5_bp_in_ready", int'(bus.in_ready), 0);
            @(negedge clk);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        $display("sample t5_bp: x=100 y=%0d held 10 cycles", $signed(bus.y_out));
        @(negedge clk);
        check("t5_bp_release_valid", int'(bus.out_valid), 0);
        check("t5_bp_release_ready", int'(bus.in_ready), 1);
        repeat (3) @(negedge clk);
        check("t5_bp_not_consumed", int'(bus.out_valid), 0);

        // Config write during MAC is dropped with a one-cycle pulse.
        start_sample(50, 1'b0, 0, 0);
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = 3'd0;
        bus.cfg_wdata = '0;
        @(negedge clk);
        bus.cfg_we = 1'b0;
        check("t5_drop_pulse", int'(bus.cfg_drop), 1);
        @(negedge clk);
        check("t5_drop_end", int'(bus.cfg_drop), 0);
        wait_out(lat, ir_hi, y);
        check("t5_drop_valid", int'(bus.out_valid), 1);
        check("t5_drop_y", y, 50);
        $display("sample t5_drop: x=50 y=%0d", y);
        @(negedge clk);
        send("t5_after_drop", 20, 20, 0, 1'b0, 0, 0);

        // Reset during MAC tap 2 with non-default b0 and sat_flag set.
        send("t6_pre_sat", 10000, 16383, 1, 1'b1, 0, 24576);
        start_sample(8, 1'b0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("t6_rst_in_ready",  int'(bus.in_ready),  1);
        check("t6_rst_out_valid", int'(bus.out_valid), 0);
        check("t6_rst_y_out",     int'(bus.y_out),     0);
        check("t6_rst_sat",       int'(bus.sat_flag),  0);
        check("t6_rst_cfg_drop",  int'(bus.cfg_drop),  0);
        $display("reset t6: mid-MAC reset applied, y_out=%0d", bus.y_out);
        @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        check("t6_no_output", int'(bus.out_valid), 0);
        send("t6_after_rst", 7, 7, 0, 1'b0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/iir_mac_seq.md
Name: iir_mac_seq

Overview:
- Sequencer for a single-multiplier, direct-form-I, second-order IIR section.
- Accepts one 15-bit signed sample per valid/ready handshake.
- Time-shares one multiplier across the five taps and produces one saturated 15-bit output per sample.
- Coefficients are held in registers on a small config write port. The block sits in the filter path in place of a fully parallel iir stage, trading throughput for area.

Parameters:
- DATA_W, 15, sample width (signed, two's complement), x_in and y_out.
- COEF_W, 16, coefficient width (signed).
- FRAC, 13, coefficient fractional bits (Q2.13; 8192 = 1.0).
- ACC_W, 34, accumulator width (DATA_W+COEF_W+3 guard bits).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- x_in  in  DATA_W  input sample
- in_valid  in  1  x_in valid
- in_ready  out  1  block can accept a sample
- y_out  out  DATA_W  filtered output sample
- out_valid  out  1  y_out valid
- out_ready  in  1  consumer accepts y_out
- cfg_we  in  1  config write strobe
- cfg_addr  in  3  0=b0, 1=b1, 2=b2, 3=a1, 4=a2, 5=clear history, 6-7 no effect
- cfg_wdata  in  COEF_W  coefficient value (ignored for addr 5)
- cfg_drop  out  1  one-cycle pulse: config write rejected (block busy)
- sat_flag  out  1  sticky: an output saturated since reset or last clear

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; in_ready=1; out_valid=0; y_out=0; cfg_drop=0; sat_flag=0.
  - History x1, x2, y1, y2 = 0; accumulator = 0.
  - b0=8192; b1=b2=a1=a2=0 (passthrough).
- Equation: y = (b0*x0 + b1*x1 + b2*x2 - a1*y1 - a2*y2 + 2^(FRAC-1)) >>> FRAC.
  - The shift is arithmetic, giving round-half-up.
  - The result is saturated to [-16384, 16383].
  - All products are signed and sign-extended to ACC_W; no intermediate wrap.
- FSM states: IDLE, MAC, ROUND, OUT.
  - IDLE: in_ready=1. On in_valid&in_ready, latch x0, clear acc, tap=0, go to MAC.
  - MAC: one product per cycle, tap 0..4 in order b0x0, b1x1, b2x2, -a1y1, -a2y2, accumulated. After tap 4, go to ROUND. in_ready=0.
  - ROUND: compute rounded, saturated y, then:
    - Set y_out<=y.
    - Shift history: x2<=x1, x1<=x0, y2<=y1, y1<=y (saturated value).
    - Set sat_flag if clamped.
    - Go to OUT.
  - OUT: out_valid=1 and y_out held stable until out_ready=1. The handshake cycle returns to IDLE; out_valid drops the next cycle.
- Latency and throughput:
  - Accept edge at cycle T → out_valid high from T+7.
  - Minimum 8 cycles per sample (out_ready tied high).
- in_ready is combinationally equal to (state==IDLE). There is no skid buffer; in_valid outside IDLE is ignored, with no queueing.
- Config writes are honoured only in IDLE and take effect the next cycle.
  - cfg_we outside IDLE: write discarded, cfg_drop pulses for 1 cycle, registers unchanged.
  - Addr 5 in IDLE zeroes x1, x2, y1, y2 and clears sat_flag.
  - Addr 6-7 in IDLE: no effect, no cfg_drop.
- Simultaneous cfg_we and in_valid in IDLE: both are taken. The sample is processed with the new coefficient; addr 5 clears history before the sample uses it.
- Reset mid-operation (any state) aborts the sample; no output is produced and all registers return to reset values.
- Coefficients are never modified by the FSM.

Test Plan:
1. Reset defaults, out_ready=1: send 1000, 4, -5 → y_out 1000, 4, -5; each out_valid exactly 7 cycles after its accept; in_ready low for 7 cycles after each accept.
2. Write b0=4096 (0.5): send 1000, 3, -3 → 500, 2 (1.5 rounds up), -1 (-1.5 rounds up).
3. Recursion, b0=8192 and a1=-4096 (y = x + 0.5*y1): impulse 1000 then zeros → 1000, 500, 250, 125, 63, 32; then write addr 5 and send 0 → 0.
4. Saturation, b0=24576 (3.0): send 10000 → 16383, sat_flag=1; send -10000 → -16384; write addr 5 → sat_flag=0.
5. Backpressure and drops:
   - Hold out_ready=0 for 10 cycles in OUT → y_out and out_valid stable, in_ready=0, a presented sample is not consumed.
   - cfg write b0=0 during MAC → cfg_drop pulse, next output still uses the old b0.
6. Reset mid-op: assert rst during MAC tap 2 with non-default coefficients → immediate IDLE, outputs 0, coefficients back to defaults; after release, send 7 → 7.
